// File: rtl/adc_8ch_averager_pkg.sv
// Shared constants and state types for the 8-channel ADC averaging path.
package adc_8ch_averager_pkg;

   localparam int NUM_CH     = 8;
   localparam int CH_W       = 3;
   localparam int ADC_DATA_W = 12;

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      ACQ_WAIT,
      ACQ_SYNC,
      ACQ_COLLECT
   } acq_state_t;

   typedef enum logic {
      OUT_IDLE,
      OUT_SEND
   } out_state_t;

endpackage

// File: rtl/adc_avg_serializer.sv
// Holds one averaged set in snapshot registers and walks it out over channels 0..7
// on a valid/ready port; flags a sticky overrun when a new set arrives while busy.
module adc_avg_serializer
   import adc_8ch_averager_pkg::*;
#(
   parameter int DATA_W = ADC_DATA_W
) (
   input  logic                           clk,
   input  logic                           rst_l,
   input  logic                           load,
   input  logic [NUM_CH-1:0][DATA_W-1:0]  avg,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [DATA_W-1:0]              m_data,
   output logic [CH_W-1:0]                m_chan,
   output logic                           m_last,
   output logic                           overrun_o
);

   out_state_t                     state;
   logic [NUM_CH-1:0][DATA_W-1:0]  snap;
   logic                           start;
   logic                           handshake;
   logic                           idle;
   logic [CH_W-1:0]                nxt_ch;

   // A set may land in the same cycle the channel-7 word is handed off.
   always_comb begin
      handshake = m_valid & m_ready;
      idle      = (state == OUT_IDLE) | (handshake & m_last);
      nxt_ch    = m_chan + CH_W'(1);
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state     <= OUT_IDLE;
         snap      <= '0;
         start     <= 1'b0;
         overrun_o <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_chan    <= '0;
         m_last    <= 1'b0;
      end else begin
         start <= 1'b0;
         if (load) begin
            if (idle) begin
               snap  <= avg;
               start <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end

         unique case (state)
            OUT_IDLE: begin
               if (start) begin
                  state   <= OUT_SEND;
                  m_valid <= 1'b1;
                  m_chan  <= '0;
                  m_data  <= snap[0];
                  m_last  <= 1'b0;
               end
            end
            OUT_SEND: begin
               if (handshake) begin
                  if (m_last) begin
                     state   <= OUT_IDLE;
                     m_valid <= 1'b0;
                     m_chan  <= '0;
                     m_data  <= '0;
                     m_last  <= 1'b0;
                  end else begin
                     m_chan <= nxt_ch;
                     m_data <= snap[nxt_ch];
                     m_last <= (nxt_ch == LAST_CH);
                  end
               end
            end
            default: state <= OUT_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/adc_8ch_averager.sv
// Periodically syncs the serial ADC sequencer, captures its 8-sample frames and
// averages 2^AVG_LOG2 frames per channel before handing the set to the serializer.
module adc_8ch_averager
   import adc_8ch_averager_pkg::*;
#(
   parameter int DATA_W      = ADC_DATA_W,
   parameter int AVG_LOG2    = 2,
   parameter int SYNC_PERIOD = 4096,
   parameter int TIMEOUT     = 1024
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              en,
   input  logic              rd_en_i,
   input  logic [CH_W-1:0]   channel_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              sync_o,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CH_W-1:0]   m_chan,
   output logic              m_last,
   output logic              overrun_o,
   output logic              err_o
);

   localparam int ACC_W      = DATA_W + AVG_LOG2;
   localparam int P_W        = $clog2(SYNC_PERIOD);
   localparam int T_W        = $clog2(TIMEOUT + 1);
   localparam int F_W        = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int NUM_FRAMES = 1 << AVG_LOG2;

   localparam logic [P_W-1:0] P_LAST = P_W'(SYNC_PERIOD - 1);
   localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT - 1);
   localparam logic [F_W-1:0] F_LAST = F_W'(NUM_FRAMES - 1);

   acq_state_t                    state;
   logic [P_W-1:0]                pcnt;
   logic [T_W-1:0]                tcnt;
   logic [F_W-1:0]                fcnt;
   logic [CH_W-1:0]               exp_ch;
   logic                          set_done;

   logic                          rd_q;
   logic [CH_W-1:0]               ch_l;
   logic [DATA_W-1:0]             dat_l;
   logic                          smp_v;

   logic [NUM_CH-1:0][ACC_W-1:0]  acc;
   logic [NUM_CH-1:0][DATA_W-1:0] avg;

   logic in_collect;
   logic accept;
   logic seq_err;
   logic timeout;
   logic abort;

   always_comb begin
      in_collect = (state == ACQ_COLLECT);
      accept     = in_collect & smp_v & (ch_l == exp_ch);
      seq_err    = in_collect & smp_v & (ch_l != exp_ch);
      // A sample arriving on the expiry cycle wins over the timeout.
      timeout    = in_collect & ~smp_v & (tcnt == T_LAST);
      abort      = seq_err | timeout;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_q  <= 1'b0;
         ch_l  <= '0;
         dat_l <= '0;
         smp_v <= 1'b0;
      end else begin
         rd_q  <= rd_en_i;
         smp_v <= 1'b0;
         if (in_collect) begin
            if (rd_en_i && !rd_q) begin
               ch_l <= channel_i;
            end
            if (!rd_en_i && rd_q) begin
               dat_l <= data_i;
               smp_v <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state    <= ACQ_WAIT;
         pcnt     <= '0;
         tcnt     <= '0;
         fcnt     <= '0;
         exp_ch   <= '0;
         set_done <= 1'b0;
         sync_o   <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         sync_o   <= 1'b0;
         err_o    <= 1'b0;
         set_done <= 1'b0;
         unique case (state)
            ACQ_WAIT: begin
               if (pcnt == P_LAST) begin
                  if (en) begin
                     state  <= ACQ_SYNC;
                     sync_o <= 1'b1;
                  end
               end else begin
                  pcnt <= pcnt + P_W'(1);
               end
            end
            ACQ_SYNC: begin
               exp_ch <= '0;
               tcnt   <= '0;
               state  <= ACQ_COLLECT;
            end
            ACQ_COLLECT: begin
               if (abort) begin
                  err_o <= 1'b1;
                  fcnt  <= '0;
                  pcnt  <= '0;
                  state <= ACQ_WAIT;
               end else if (accept) begin
                  exp_ch <= exp_ch + CH_W'(1);
                  tcnt   <= '0;
                  if (exp_ch == LAST_CH) begin
                     fcnt     <= (fcnt == F_LAST) ? '0 : fcnt + F_W'(1);
                     set_done <= (fcnt == F_LAST);
                     pcnt     <= '0;
                     state    <= ACQ_WAIT;
                  end
               end else begin
                  tcnt <= tcnt + T_W'(1);
               end
            end
            default: state <= ACQ_WAIT;
         endcase
      end
   end

   // set_done lags the final accumulate by one cycle, so acc already holds the last sample.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         acc <= '0;
      end else if (abort || set_done) begin
         acc <= '0;
      end else if (accept) begin
         acc[ch_l] <= acc[ch_l] + ACC_W'(dat_l);
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         avg[i] = DATA_W'(acc[i] >> AVG_LOG2);
      end
   end

   adc_avg_serializer #(
      .DATA_W (DATA_W)
   ) u_serializer (
      .clk       (clk),
      .rst_l     (rst_l),
      .load      (set_done),
      .avg       (avg),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_chan    (m_chan),
      .m_last    (m_last),
      .overrun_o (overrun_o)
   );

endmodule
